// File: rtl/ext_pkg.sv
// Shared types and constants for the immediate-extension pipeline.
// Holds the immediate-kind tag, MIPS opcode/funct encodings and a sign-extend helper.
package ext_pkg;

  typedef enum logic [2:0] {
    K_NONE   = 3'd0,
    K_SEXT   = 3'd1,
    K_ZEXT   = 3'd2,
    K_SHAMT  = 3'd3,
    K_LUI    = 3'd4,
    K_BRANCH = 3'd5
  } kind_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  // Replicate bit w-1 of x into all bits above it.
  function automatic logic [63:0] sext(input logic [63:0] x,
                                       input int w);
    logic [63:0] r;
    for (int i = 0; i < 64; i++)
      r[i] = (i < w) ? x[i] : x[w-1];
    return r;
  endfunction

endpackage

// File: rtl/ext_decode.sv
// Combinational immediate decoder: raw MIPS word in,
// extended immediate and kind tag out.
module ext_decode
  import ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output kind_t           kind
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] raw;
  logic [4:0]  sh;
  logic        is_sext;
  logic        is_zext;
  logic        is_lui;
  logic        is_br;
  logic        is_sh;
  logic        unused_bits;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign raw   = instr[15:0];
  assign sh    = instr[10:6];

  // Register-specifier fields carry no immediate content.
  assign unused_bits = ^instr[25:16];

  assign is_sext = op inside {OP_ADDI, OP_ADDIU, OP_SLTI,
                              OP_SLTIU, OP_LB, OP_LH, OP_LW,
                              OP_LBU, OP_LHU, OP_SB, OP_SH,
                              OP_SW};
  assign is_zext = op inside {OP_ANDI, OP_ORI, OP_XORI};
  assign is_lui  = (op == OP_LUI);
  assign is_br   = op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
  assign is_sh   = (op == OP_SPECIAL) &&
                   (funct inside {FN_SLL, FN_SRL, FN_SRA});

  always_comb begin
    imm  = '0;
    kind = K_NONE;
    unique case (1'b1)
      is_sext: begin
        kind = K_SEXT;
        imm  = XLEN'(sext({48'h0, raw}, 16));
      end
      is_zext: begin
        kind = K_ZEXT;
        imm  = XLEN'(raw);
      end
      is_lui: begin
        kind = K_LUI;
        imm  = XLEN'(sext({32'h0, raw, 16'h0}, 32));
      end
      is_br: begin
        kind = K_BRANCH;
        imm  = XLEN'(sext({48'h0, raw}, 16) << 2);
      end
      is_sh: begin
        kind = K_SHAMT;
        imm  = XLEN'(sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Elastic DEPTH-stage immediate-generation pipeline with
// valid/ready handshake and synchronous flush.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_kind
);

  logic [XLEN-1:0] dec_imm;
  kind_t           dec_kind;
  logic            take;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic            v_q    [DEPTH];
  logic [XLEN-1:0] imm_q  [DEPTH];
  kind_t           kind_q [DEPTH];

  ext_decode #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .imm   (dec_imm),
    .kind  (dec_kind)
  );

  assign take     = in_valid && in_ready && !flush;
  assign in_ready = rdy[0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic            src_v;
    logic [XLEN-1:0] src_imm;
    kind_t           src_kind;

    assign v[i] = v_q[i];
    // Slot can load iff some slot at or after it is free,
    // or the head drains: closed form of the ready chain.
    assign rdy[i] = out_ready || !(&v[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign src_v    = take;
      assign src_imm  = dec_imm;
      assign src_kind = dec_kind;
    end else begin : g_body
      assign src_v    = v_q[i-1];
      assign src_imm  = imm_q[i-1];
      assign src_kind = kind_q[i-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[i]    <= 1'b0;
        imm_q[i]  <= '0;
        kind_q[i] <= K_NONE;
      end else begin
        if (flush)
          v_q[i] <= 1'b0;
        else if (rdy[i])
          v_q[i] <= src_v;
        if (rdy[i] && src_v) begin
          imm_q[i]  <= src_imm;
          kind_q[i] <= src_kind;
        end
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_imm   = imm_q[DEPTH-1];
  assign out_kind  = kind_q[DEPTH-1];

endmodule
